fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 32: instruction word width in bits.
REQ-002 Parameter RESET_PC, default 64'h0: 64-bit byte address of the first fetch after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is sampled on clk.
REQ-005 start  input  1  level; moves IDLE to RUN.
REQ-006 imem_addr  output  6  word address to instruction ROM, equal to pc[7:2].
REQ-007 imem_q  input  N  combinational ROM read data for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse or level.
REQ-009 redirect_pc  input  64  redirect byte address.
REQ-010 instr  output  N  registered fetched instruction.
REQ-011 instr_pc  output  64  byte address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a valid word.
REQ-013 instr_ready  input  1  consumer accepts instr when instr_valid and instr_ready are both high.
REQ-014 halted  output  1  high while in HALT.
REQ-015 fetch_count  output  32  count of accepted instructions, saturating at 32'hFFFF_FFFF.

Function
REQ-016 States: IDLE, RUN, HALT; IDLE->RUN when start=1; RUN->HALT on halt condition; HALT->RUN only on redirect_valid; no other transitions.
REQ-017 pc is a 64-bit internal register; imem_addr = pc[7:2] combinationally in all states.
REQ-018 Fire condition: state==RUN and (instr_valid==0 or instr_ready==1) and redirect_valid==0.
REQ-019 On fire with pc[63:8]==0: instr<=imem_q, instr_pc<=pc, instr_valid<=1, pc<=pc+4; latency one cycle from pc to instr_valid.
REQ-020 On fire with pc[63:8]!=0 (out of ROM range): instr_valid<=0, pc unchanged, state<=HALT.
REQ-021 When instr_valid=1 and instr_ready=0, instr, instr_pc and instr_valid are held unchanged.
REQ-022 Acceptance with no new fire (HALT or IDLE) clears instr_valid next edge.
REQ-023 redirect_valid=1 in any state except IDLE: pc<={redirect_pc[63:2],2'b00}, instr_valid<=0 (flush, even if instr_ready=1 that cycle), state<=RUN; first fetch of target occurs the following cycle.
REQ-024 Redirect has priority over fire, halt and stall in the same cycle; redirect_valid in IDLE is ignored.
REQ-025 fetch_count increments by 1 on each accepted handshake, including the one in a redirect cycle; saturates, never wraps.
REQ-026 pc+4 wraps modulo 2^64; wrap lands in range, no special handling.

Reset
REQ-027 On reset low: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
REQ-028 Reset asserted mid-handshake discards the pending instruction; no acceptance is counted.

Configuration
REQ-029 Macro FETCH_HALT_ON_ZERO_EN defined: a fire where imem_q==0 does not issue; instr_valid<=0, pc unchanged, state<=HALT (zero-filled ROM tail stops the fetcher).
REQ-030 Macro FETCH_HALT_ON_ZERO_EN undefined: zero words are issued like any other instruction; HALT reached only through REQ-020.

Verification
REQ-031 ROM[0]=32'hb5000017, reset release, start=1, instr_ready=1 -> 2nd edge after start: instr=32'hb5000017, instr_pc=0, instr_valid=1; next edge instr_pc=4.
REQ-032 instr_ready=0 for 3 cycles while instr_valid=1 at instr_pc=8 -> instr, instr_pc=8 stable 3 cycles, pc stays 12, fetch_count unchanged.
REQ-033 redirect_valid=1, redirect_pc=64'h23 during stall -> next edge instr_valid=0, pc=64'h20; following edge instr_pc=64'h20.
REQ-034 With FETCH_HALT_ON_ZERO_EN and ROM[1..63]=0 -> instr_pc=0 issued, then halted=1, instr_valid=0, fetch_count=1; without macro, words at pc 4..252 issued, halted=1 after pc=256.
REQ-035 reset pulsed low mid-run between edges with instr_valid=1 -> outputs at REQ-027 values immediately, before next clk edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALT sequencer with a 64-bit pc feeding a 64-word ROM.
// Latency: one cycle from pc to a registered instr/instr_pc/instr_valid; a redirect costs one bubble.
// Backpressure: instr_valid with instr_ready low holds the output word and stalls pc (valid/ready).
// Option: define FETCH_HALT_ON_ZERO_EN to stop fetching (enter HALT) when a zero ROM word is read.
module fetch_ctrl #(
    parameter int          N        = 32,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [5:0]   imem_addr,
    input  logic [N-1:0] imem_q,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic [N-1:0] instr,
    output logic [63:0]  instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         halted,
    output logic [31:0]  fetch_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [N-1:0] instr_q, instr_d;
    logic [63:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic accept;
    logic fire;
    logic redirect;
    logic out_of_range;
    logic zero_stop;

    // Low two redirect bits are dropped: fetches are always word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr    = pc_q[7:2];
    assign accept       = instr_valid_q && instr_ready;
    assign redirect     = redirect_valid && (state_q != ST_IDLE);
    assign fire         = (state_q == ST_RUN) && (!instr_valid_q || instr_ready) && !redirect_valid;
    assign out_of_range = (pc_q[63:8] != 56'd0);

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_stop = (imem_q == '0);
`else
    assign zero_stop = 1'b0;
`endif

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = fetch_count_q;

    // Next-state: redirect wins over fire/halt/stall; acceptances are counted even in a redirect cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;

        if (accept && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (redirect) begin
            pc_d          = {redirect_pc[63:2], 2'b00};
            instr_valid_d = 1'b0;
            state_d       = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                    if (accept) begin
                        instr_valid_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (out_of_range || zero_stop) begin
                            instr_valid_d = 1'b0;
                            state_d       = ST_HALT;
                        end else begin
                            instr_d       = imem_q;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + 64'd4;
                        end
                    end
                end
                ST_HALT: begin
                    if (accept) begin
                        instr_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset asserts immediately and discards any pending word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= 64'd0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// A global time limit guarantees termination.
module tb_fetch_ctrl;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit ZERO_HALT = 1'b1;
`else
    localparam bit ZERO_HALT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [64];
    assign imem_q = rom[imem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl #(.N(32), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_q(imem_q),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: fetcher mode, program counter, output slot and acceptance tally.
    typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;
    mode_t       m_mode;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr, m_cnt;
    bit          m_valid;

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 64'd0; m_ipc = 64'd0;
        m_instr = 32'd0; m_cnt = 32'd0; m_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit          taken;
        logic [31:0] word;
        if (!reset) begin
            model_reset();
            return;
        end
        taken = m_valid && instr_ready;
        if (taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        word = rom[(m_pc >> 2) % 64];
        if (redirect_valid && m_mode != M_IDLE) begin
            m_pc = redirect_pc - (redirect_pc % 4);
            m_valid = 1'b0;
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!m_valid || instr_ready) begin
                if (m_pc >= 64'd256 || (ZERO_HALT && word == 32'd0)) begin
                    m_valid = 1'b0;
                    m_mode = M_HALT;
                end else begin
                    m_instr = word; m_ipc = m_pc; m_valid = 1'b1;
                    m_pc = m_pc + 4;
                end
            end
        end else begin
            if (m_mode == M_IDLE && start) m_mode = M_RUN;
            if (taken) m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        start = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({instr_valid, halted, instr, instr_pc, fetch_count, imem_addr} !== 136'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b halted=%0b instr=%h pc=%h cnt=%0d addr=%0d, need all zero",
                     instr_valid, halted, instr, instr_pc, fetch_count, imem_addr);
        end
    endtask

    task automatic test_first_fetch_and_stall();
        for (int i = 0; i < 64; i++) rom[i] = $urandom | 32'h1;
        rom[0] = 32'hb500_0017;
        apply_reset();
        start = 1; instr_ready = 1;
        tick();
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_edge_valid: got %0b need 0", instr_valid);
        end
        tick();
        n_tests++;
        if (instr !== 32'hb500_0017 || instr_pc !== 64'd0 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch: instr=%h pc=%h valid=%0b need b5000017/0/1", instr, instr_pc, instr_valid);
        end
        tick();
        n_tests++;
        if (instr_pc !== 64'd4 || instr !== rom[1]) begin
            n_fail++; $display("FAIL second_fetch: pc=%h instr=%h need 4/%h", instr_pc, instr, rom[1]);
        end
        tick();
        instr_ready = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (instr_pc !== 64'd8 || instr !== rom[2] || instr_valid !== 1'b1 || imem_addr !== 6'd3 || fetch_count !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h instr=%h valid=%0b addr=%0d cnt=%0d need 8/%h/1/3/2",
                         c, instr_pc, instr, instr_valid, imem_addr, fetch_count, rom[2]);
            end
        end
        redirect_valid = 1; redirect_pc = 64'h23;
        tick();
        n_tests++;
        if (instr_valid !== 1'b0 || imem_addr !== 6'd8 || fetch_count !== 32'd2) begin
            n_fail++;
            $display("FAIL redirect_flush: valid=%0b addr=%0d cnt=%0d need 0/8/2", instr_valid, imem_addr, fetch_count);
        end
        redirect_valid = 0;
        tick();
        n_tests++;
        if (instr_pc !== 64'h20 || instr_valid !== 1'b1 || instr !== rom[8]) begin
            n_fail++;
            $display("FAIL redirect_target: pc=%h valid=%0b instr=%h need 20/1/%h", instr_pc, instr_valid, instr, rom[8]);
        end
    endtask

    task automatic test_rom_end_halt();
        int cyc;
        rom[0] = 32'h0000_0013;
        for (int i = 1; i < 64; i++) rom[i] = 32'd0;
        apply_reset();
        start = 1; instr_ready = 1;
        cyc = 0;
        while (!halted && cyc < 300) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (!halted) begin
            n_fail++; $display("FAIL halt_timeout: halted=%0b after %0d cycles, need 1", halted, cyc);
        end
        n_tests++;
        if (ZERO_HALT) begin
            if (fetch_count !== 32'd1 || instr_valid !== 1'b0 || instr_pc !== 64'd0) begin
                n_fail++;
                $display("FAIL halt_zero: cnt=%0d valid=%0b pc=%h need 1/0/0", fetch_count, instr_valid, instr_pc);
            end
        end else begin
            if (fetch_count !== 32'd64 || instr_valid !== 1'b0 || instr_pc !== 64'd252 || imem_addr !== 6'd0) begin
                n_fail++;
                $display("FAIL halt_range: cnt=%0d valid=%0b pc=%h addr=%0d need 64/0/fc/0",
                         fetch_count, instr_valid, instr_pc, imem_addr);
            end
        end
        tick();
        tick();
        n_tests++;
        if (!halted || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_sticky: halted=%0b valid=%0b need 1/0", halted, instr_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 64; i++) rom[i] = $urandom | 32'h1;
        apply_reset();
        start = 1; instr_ready = 1;
        for (int c = 0; c < 5; c++) tick();
        instr_ready = 0;
        tick();
        #2;
        reset = 0;
        #1;
        n_tests++;
        if ({instr_valid, halted, instr, instr_pc, fetch_count, imem_addr} !== 136'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b halted=%0b instr=%h pc=%h cnt=%0d addr=%0d, need all zero",
                     instr_valid, halted, instr, instr_pc, fetch_count, imem_addr);
        end
        model_reset();
        tick();
        reset = 1;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 64; i++) rom[i] = ($urandom % 8 == 0) ? 32'd0 : $urandom;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom % 4 == 0);
            instr_ready    = ($urandom % 3 != 0);
            redirect_valid = ($urandom % 10 == 0);
            redirect_pc    = ($urandom % 5 == 0) ? {$urandom, $urandom} : 64'($urandom % 256);
            tick();
            n_tests++;
            if (instr_valid !== m_valid || instr !== m_instr || instr_pc !== m_ipc || fetch_count !== m_cnt ||
                halted !== (m_mode == M_HALT) || imem_addr !== 6'((m_pc % 256) / 4)) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: v=%0b i=%h pc=%h cnt=%0d h=%0b a=%0d need v=%0b i=%h pc=%h cnt=%0d h=%0b a=%0d",
                             c, instr_valid, instr, instr_pc, fetch_count, halted, imem_addr,
                             m_valid, m_instr, m_ipc, m_cnt, (m_mode == M_HALT), (m_pc % 256) / 4);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        #1;
        test_reset();
        test_first_fetch_and_stall();
        test_rom_end_halt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
